// File: rtl/lcd_clk_ctrl_pkg.sv
// lcd_clk_pkg: FSM states, panel IDs, strap codes and strap-code decoder for lcd_clk_ctrl
package lcd_clk_pkg;
  localparam logic [1:0] SETTLE = 2'd0;
  localparam logic [1:0] SAMPLE = 2'd1;
  localparam logic [1:0] START  = 2'd2;
  localparam logic [1:0] RUN    = 2'd3;
  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;
  localparam logic [2:0] CODE_4342 = 3'd0;
  localparam logic [2:0] CODE_7084 = 3'd1;
  localparam logic [2:0] CODE_7016 = 3'd2;
  localparam logic [2:0] CODE_4384 = 3'd4;
  localparam logic [2:0] CODE_1018 = 3'd5;
  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  div;
    logic        err;
  } dec_t;
  // Unknown codes fall back to the slowest panel so the clock is always safe
  function automatic dec_t decode(input logic [2:0] code, input logic [3:0] ds, input logic [3:0] dm,
                                  input logic [3:0] df);
    dec_t d;
    case (code)
      CODE_4342: d = '{ID_4342, ds, 1'b0};
      CODE_7084: d = '{ID_7084, dm, 1'b0};
      CODE_7016: d = '{ID_7016, df, 1'b0};
      CODE_4384: d = '{ID_4384, dm, 1'b0};
      CODE_1018: d = '{ID_1018, df, 1'b0};
      default:   d = '{ID_4342, ds, 1'b1};
    endcase
    return d;
  endfunction
endpackage

// File: rtl/lcd_clk_ctrl_if.sv
// lcd_clk_ctrl_if: pad, request and status signals of the LCD pixel-clock controller (LCD_ID_OVERRIDE_EN adds ID override)
interface lcd_clk_ctrl_if;
  logic [23:0] lcd_rgb_in;
  logic        redetect_req;
  logic        rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;
  logic [3:0]  div_ratio;
  logic        pix_ce;
  logic        lcd_pclk;
  logic        timing_en;
`ifdef LCD_ID_OVERRIDE_EN
  logic        id_ovr_valid;
  logic [2:0]  id_ovr_code;
  modport slave (input lcd_rgb_in, redetect_req, id_ovr_valid, id_ovr_code,
                 output rgb_oe, lcd_id, id_valid, id_err, div_ratio, pix_ce, lcd_pclk, timing_en);
  modport master (output lcd_rgb_in, redetect_req, id_ovr_valid, id_ovr_code,
                  input rgb_oe, lcd_id, id_valid, id_err, div_ratio, pix_ce, lcd_pclk, timing_en);
`else
  modport slave (input lcd_rgb_in, redetect_req,
                 output rgb_oe, lcd_id, id_valid, id_err, div_ratio, pix_ce, lcd_pclk, timing_en);
  modport master (output lcd_rgb_in, redetect_req,
                  input rgb_oe, lcd_id, id_valid, id_err, div_ratio, pix_ce, lcd_pclk, timing_en);
`endif
endinterface

// File: rtl/lcd_pclk_gen.sv
// lcd_pclk_gen: pixel counter, pix_ce strobe and registered glitch-free pixel clock
module lcd_pclk_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [3:0] div_ratio_i,
  output logic       pix_ce_o,
  output logic       lcd_pclk_o,
  output logic       bnd_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       run_q, pclk_q;
  assign bnd_o      = run_q && cnt_q == div_ratio_i - 4'd1;
  assign cnt_d      = (run_q && !bnd_o) ? cnt_q + 4'd1 : 4'd0;
  assign pix_ce_o   = bnd_o;
  assign lcd_pclk_o = pclk_q;
  // run_i is the next-cycle run state, so the registered clock lines up with the count it describes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      run_q  <= 1'b0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= run_i ? cnt_d : 4'd0;
      run_q  <= run_i;
      pclk_q <= run_i && cnt_d < (div_ratio_i >> 1);
    end
endmodule

// File: rtl/lcd_clk_ctrl.sv
// lcd_clk_ctrl: LCD power-up sequencer, panel-ID strap detection and pixel clock control (option: LCD_ID_OVERRIDE_EN)
module lcd_clk_ctrl
  import lcd_clk_pkg::*;
#(
  parameter int SETTLE_CYC = 1000,
  parameter int DIV_SLOW   = 10,
  parameter int DIV_MID    = 3,
  parameter int DIV_FAST   = 2
) (
  input  logic clk,
  input  logic rst_n,
  lcd_clk_ctrl_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q;
  logic [2:0]    sync1_q, sync2_q, code;
  logic          pend_q, bnd;
  logic [15:0]   id_q;
  logic [3:0]    div_q;
  logic          err_q;
  dec_t          dec;
`ifdef LCD_ID_OVERRIDE_EN
  assign code = bus.id_ovr_valid ? bus.id_ovr_code : sync2_q;
`else
  assign code = sync2_q;
`endif
  assign dec = decode(code, 4'(DIV_SLOW), 4'(DIV_MID), 4'(DIV_FAST));
  // Sequencer; leaves RUN only on a period boundary so the pad clock never runts
  always_comb
    state_d = state_q == SETTLE ? (settle_q == SW'(SETTLE_CYC - 1) ? SAMPLE : SETTLE) :
              state_q == SAMPLE ? START :
              state_q == START  ? RUN :
              (bnd && (pend_q || bus.redetect_req)) ? SETTLE : RUN;
  // Two-flop synchroniser for the {R7, G7, B7} strap pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= 3'd0;
      sync2_q <= 3'd0;
    end else begin
      sync1_q <= {bus.lcd_rgb_in[23], bus.lcd_rgb_in[15], bus.lcd_rgb_in[7]};
      sync2_q <= sync1_q;
    end
  // State, settle counter and redetect-pending flag; pending is only collected while running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= (state_q == SETTLE && state_d == SETTLE) ? settle_q + SW'(1) : '0;
      pend_q   <= (state_q == RUN && state_d == RUN) && (pend_q || bus.redetect_req);
    end
  // Panel ID and divisor are captured only in SAMPLE, keeping div_ratio stable through RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_q  <= ID_4342;
      div_q <= 4'(DIV_SLOW);
      err_q <= 1'b0;
    end else if (state_q == SAMPLE) begin
      id_q  <= dec.id;
      div_q <= dec.div;
      err_q <= dec.err;
    end
  lcd_pclk_gen u_pclk (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (state_d == RUN),
    .div_ratio_i(div_q),
    .pix_ce_o   (bus.pix_ce),
    .lcd_pclk_o (bus.lcd_pclk),
    .bnd_o      (bnd)
  );
  assign bus.rgb_oe    = state_q == RUN;
  assign bus.timing_en = state_q == RUN;
  assign bus.id_valid  = state_q == START || state_q == RUN;
  assign bus.lcd_id    = id_q;
  assign bus.div_ratio = div_q;
  assign bus.id_err    = err_q;
endmodule

// File: tb/tb_lcd_clk_ctrl.sv
// tb_lcd_clk_ctrl: table-driven strap decode checks plus redetect, reset and override sequences
module tb_lcd_clk_ctrl;
  localparam int SC = 16;
  typedef struct {
    logic [2:0]  code;
    logic [15:0] id;
    logic [3:0]  div;
    logic        err;
    logic [9:0]  pclk_pat;
    logic [9:0]  ce_pat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass = 0;
  int total = 0;
  vec_t tv[8];
  lcd_clk_ctrl_if bus();
  lcd_clk_ctrl #(.SETTLE_CYC(SC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_code(input logic [2:0] c);
    bus.lcd_rgb_in = 24'h3C3C3C;
    bus.lcd_rgb_in[23] = c[2];
    bus.lcd_rgb_in[15] = c[1];
    bus.lcd_rgb_in[7] = c[0];
  endtask

  task automatic restart(input logic [2:0] c);
    rst_n = 1'b0;
    set_code(c);
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rgb_oe"}, 32'(bus.rgb_oe), 32'd0);
    chk({tag, "_lcd_id"}, 32'(bus.lcd_id), 32'h4342);
    chk({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
    chk({tag, "_id_err"}, 32'(bus.id_err), 32'd0);
    chk({tag, "_div"}, 32'(bus.div_ratio), 32'd10);
    chk({tag, "_pix_ce"}, 32'(bus.pix_ce), 32'd0);
    chk({tag, "_pclk"}, 32'(bus.lcd_pclk), 32'd0);
    chk({tag, "_timing_en"}, 32'(bus.timing_en), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    while (!bus.id_valid && n < 40) begin
      step(1);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    logic [9:0] pc, ce;
    bus.redetect_req = 1'b0;
`ifdef LCD_ID_OVERRIDE_EN
    bus.id_ovr_valid = 1'b0;
    bus.id_ovr_code = 3'd0;
`endif
    tv[0] = '{3'd0, 16'h4342, 4'd10, 1'b0, 10'h01F, 10'h200};
    tv[1] = '{3'd1, 16'h7084, 4'd3,  1'b0, 10'h001, 10'h004};
    tv[2] = '{3'd2, 16'h7016, 4'd2,  1'b0, 10'h001, 10'h002};
    tv[3] = '{3'd3, 16'h4342, 4'd10, 1'b1, 10'h01F, 10'h200};
    tv[4] = '{3'd4, 16'h4384, 4'd3,  1'b0, 10'h001, 10'h004};
    tv[5] = '{3'd5, 16'h1018, 4'd2,  1'b0, 10'h001, 10'h002};
    tv[6] = '{3'd6, 16'h4342, 4'd10, 1'b1, 10'h01F, 10'h200};
    tv[7] = '{3'd7, 16'h4342, 4'd10, 1'b1, 10'h01F, 10'h200};
    set_code(3'd5);
    step(2);
    check_reset("rst");
    for (int i = 0; i < 8; i++) begin
      restart(tv[i].code);
      step(SC);
      chk($sformatf("c%0d_valid_pre", i), 32'(bus.id_valid), 32'd0);
      step(1);
      chk($sformatf("c%0d_valid", i), 32'(bus.id_valid), 32'd1);
      chk($sformatf("c%0d_id", i), 32'(bus.lcd_id), 32'(tv[i].id));
      chk($sformatf("c%0d_div", i), 32'(bus.div_ratio), 32'(tv[i].div));
      chk($sformatf("c%0d_err", i), 32'(bus.id_err), 32'(tv[i].err));
      chk($sformatf("c%0d_oe_start", i), 32'(bus.rgb_oe), 32'd0);
      step(1);
      chk($sformatf("c%0d_oe_run", i), 32'(bus.rgb_oe), 32'd1);
      chk($sformatf("c%0d_ten_run", i), 32'(bus.timing_en), 32'd1);
      pc = '0;
      ce = '0;
      for (int k = 0; k < int'(tv[i].div); k++) begin
        pc[k] = bus.lcd_pclk;
        ce[k] = bus.pix_ce;
        step(1);
      end
      chk($sformatf("c%0d_pclk_pat", i), 32'(pc), 32'(tv[i].pclk_pat));
      chk($sformatf("c%0d_ce_pat", i), 32'(ce), 32'(tv[i].ce_pat));
      chk($sformatf("c%0d_pclk_wrap", i), 32'(bus.lcd_pclk), 32'd1);
    end
    restart(3'd0);
    step(SC + 2 + 3);
    bus.redetect_req = 1'b1;
    set_code(3'd2);
    step(1);
    bus.redetect_req = 1'b0;
    chk("redet_pclk_cnt4", 32'(bus.lcd_pclk), 32'd1);
    chk("redet_ten_cnt4", 32'(bus.timing_en), 32'd1);
    step(5);
    chk("redet_ce_bnd", 32'(bus.pix_ce), 32'd1);
    chk("redet_ten_bnd", 32'(bus.timing_en), 32'd1);
    chk("redet_pclk_bnd", 32'(bus.lcd_pclk), 32'd0);
    step(1);
    chk("redet_ten_off", 32'(bus.timing_en), 32'd0);
    chk("redet_oe_off", 32'(bus.rgb_oe), 32'd0);
    chk("redet_valid_off", 32'(bus.id_valid), 32'd0);
    chk("redet_pclk_off", 32'(bus.lcd_pclk), 32'd0);
    chk("redet_ce_off", 32'(bus.pix_ce), 32'd0);
    wait_valid("redet", SC + 1);
    chk("redet_id", 32'(bus.lcd_id), 32'h7016);
    chk("redet_div", 32'(bus.div_ratio), 32'd2);
    restart(3'd0);
    step(5);
    bus.redetect_req = 1'b1;
    step(1);
    bus.redetect_req = 1'b0;
    step(12 + 25);
    chk("ign_req_ten", 32'(bus.timing_en), 32'd1);
    restart(3'd7);
    step(SC + 2 + 2);
    chk("mid_pclk_pre", 32'(bus.lcd_pclk), 32'd1);
    chk("mid_err_pre", 32'(bus.id_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    step(2);
    rst_n = 1'b1;
    wait_valid("mid_rerun", SC + 1);
    chk("mid_rerun_err", 32'(bus.id_err), 32'd1);
`ifdef LCD_ID_OVERRIDE_EN
    bus.id_ovr_valid = 1'b1;
    bus.id_ovr_code = 3'd4;
    restart(3'd0);
    wait_valid("ovr", SC + 1);
    chk("ovr_id", 32'(bus.lcd_id), 32'h4384);
    chk("ovr_div", 32'(bus.div_ratio), 32'd3);
    chk("ovr_err", 32'(bus.id_err), 32'd0);
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
